// File: rtl/uart_intr_fifo.sv
// Multi-channel UART receive interrupt: per-channel byte FIFOs feeding one irr/ack handshake.
// Optional macro UART_INTR_FIFO_RR_EN selects round-robin arbitration instead of fixed priority.
module uart_intr_fifo #(
    parameter int  CH    = 2,
    parameter int  DEPTH = 4,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH-1:0]     uart_update,
    input  logic [8*CH-1:0]   uart_data,
    input  logic              ack,
    input  logic [CH-1:0]     ovf_clr,
    output logic              irr,
    output logic [7:0]        r_data,
    output logic [CW-1:0]     r_chan,
    output logic [CH-1:0]     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;

    logic [1:0]    r_state;
    logic [7:0]    r_mem   [CH][DEPTH];
    logic [AW-1:0] r_wptr  [CH];
    logic [AW-1:0] r_rptr  [CH];
    logic [AW:0]   r_count [CH];
    logic [CH-1:0] r_overflow;

    logic [CH-1:0] w_nonempty;
    logic [CH-1:0] w_full;
    logic [CH-1:0] w_pop;
    logic [CH-1:0] w_push;
    logic [CH-1:0] w_ovf_set;
    logic          w_any;
    logic [CW-1:0] w_grant;
    logic [7:0]    w_head;

    assign irr      = (r_state == S_PRESENT);
    assign overflow = r_overflow;
    assign w_any    = |w_nonempty;

    // A pop frees the slot a same-cycle push needs, so a full FIFO accepts push+pop together.
    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        w_pop      = '0;
        w_push     = '0;
        w_ovf_set  = '0;
        for (int k = 0; k < CH; k++) begin
            w_nonempty[k] = (r_count[k] != '0);
            w_full[k]     = (r_count[k] == FULL_COUNT);
            w_pop[k]      = (r_state == S_PRESENT) && ack && (r_chan == CW'(k));
            w_push[k]     = uart_update[k] && (!w_full[k] || w_pop[k]);
            w_ovf_set[k]  = uart_update[k] && w_full[k] && !w_pop[k];
        end
    end

`ifdef UART_INTR_FIFO_RR_EN
    logic [CW-1:0] r_rr_start;
    logic [CW-1:0] w_grant_lo;
    logic [CW-1:0] w_grant_hi;
    logic          w_found_hi;

    // Prefer the lowest non-empty channel at or above the start point, else wrap to the lowest overall.
    always_comb begin
        w_grant_lo = '0;
        w_grant_hi = '0;
        w_found_hi = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (w_nonempty[i]) begin
                w_grant_lo = CW'(i);
            end
            if (w_nonempty[i] && (CW'(i) >= r_rr_start)) begin
                w_grant_hi = CW'(i);
                w_found_hi = 1'b1;
            end
        end
        w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_start <= '0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_rr_start <= (w_grant == CW'(CH - 1)) ? '0 : w_grant + 1'b1;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (w_nonempty[i]) begin
                w_grant = CW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_head = '0;
        for (int k = 0; k < CH; k++) begin
            if (w_grant == CW'(k)) begin
                w_head = r_mem[k][r_rptr[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k]] <= uart_data[8*k +: 8];
            end
        end
    end

    // Set beats clear when a new overflow and ovf_clr land in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CH; k++) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_count[k] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + 1'b1;
                end
                r_count[k]    <= r_count[k] + (AW+1)'(w_push[k]) - (AW+1)'(w_pop[k]);
                r_overflow[k] <= w_ovf_set[k] | (r_overflow[k] & ~ovf_clr[k]);
            end
        end
    end

    // The presented byte stays in its FIFO until ack; GAP guarantees irr drops between bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_chan  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_data  <= w_head;
                        r_chan  <= w_grant;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ack) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_intr_fifo.sv
// Directed bench for uart_intr_fifo (CH=2, DEPTH=4): latency, ordering, overflow, arbitration, reset.
module tb_uart_intr_fifo;

    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 1;

    logic              clk;
    logic              reset;
    logic [CH-1:0]     uart_update;
    logic [8*CH-1:0]   uart_data;
    logic              ack;
    logic [CH-1:0]     ovf_clr;
    logic              irr;
    logic [7:0]        r_data;
    logic [CW-1:0]     r_chan;
    logic [CH-1:0]     overflow;

    int n_checks;
    int n_bad;
    logic [7:0] exp_q[$];

    uart_intr_fifo #(.CH(CH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_update(uart_update),
        .uart_data  (uart_data),
        .ack        (ack),
        .ovf_clr    (ovf_clr),
        .irr        (irr),
        .r_data     (r_data),
        .r_chan     (r_chan),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        uart_update = '0;
        uart_update[ch] = 1'b1;
        uart_data[8*ch +: 8] = b;
        tick();
        uart_update = '0;
    endtask

    task automatic wait_irr(input string tag);
        int n;
        n = 0;
        while (irr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(irr), 32'd1);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_d, input logic [CW-1:0] exp_c);
        wait_irr({tag, "_irr"});
        check({tag, "_data"}, 32'(r_data), 32'(exp_d));
        check({tag, "_chan"}, 32'(r_chan), 32'(exp_c));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_gap"}, 32'(irr), 32'd0);
        tick();
        check({tag, "_idle"}, 32'(irr), 32'd0);
    endtask

    task automatic drain_q(input string tag, input logic [CW-1:0] exp_c);
        while (exp_q.size() > 0) begin
            read_byte(tag, exp_q.pop_front(), exp_c);
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (irr !== 1'b0) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [9:0] irr_trace;
        int pops;
        n_checks    = 0;
        n_bad       = 0;
        reset       = 1'b1;
        uart_update = '0;
        uart_data   = '0;
        ack         = 1'b0;
        ovf_clr     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_irr", 32'(irr), 32'd0);
        check("rst_data", 32'(r_data), 32'd0);
        check("rst_chan", 32'(r_chan), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single byte: irr rises two cycles after the update pulse.
        push(0, 8'h41);
        check("lat_t1_irr", 32'(irr), 32'd0);
        tick();
        check("lat_t2_irr", 32'(irr), 32'd1);
        check("lat_t2_data", 32'(r_data), 32'h41);
        check("lat_t2_chan", 32'(r_chan), 32'd0);
        read_byte("single", 8'h41, 1'b0);
        quiet("single_quiet", 6);
        check("single_hold_data", 32'(r_data), 32'h41);

        // FIFO order across pointer wrap on channel 1.
        for (int i = 0; i < 3; i++) begin
            push(1, 8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        drain_q("wrap_a", 1'b1);
        for (int i = 0; i < 4; i++) begin
            push(1, 8'(8'h13 + i));
            exp_q.push_back(8'(8'h13 + i));
        end
        drain_q("wrap_b", 1'b1);
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Overflow: fifth push on a full channel is dropped and flagged.
        for (int i = 0; i < 5; i++) push(0, 8'(8'hA0 + i));
        check("ovf_set", 32'(overflow), 32'b01);
        for (int i = 0; i < 4; i++) read_byte("ovf_rd", 8'(8'hA0 + i), 1'b0);
        quiet("ovf_dropped", 5);
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr = '0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push into a full FIFO in the same cycle as the ack pop.
        for (int i = 0; i < 4; i++) push(0, 8'(8'hB0 + i));
        wait_irr("full_pp_irr");
        check("full_pp_head", 32'(r_data), 32'hB0);
        uart_update[0] = 1'b1;
        uart_data[7:0] = 8'hB4;
        ack = 1'b1;
        tick();
        uart_update = '0;
        ack = 1'b0;
        check("full_pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 5; i++) exp_q.push_back(8'(8'hB0 + i));
        drain_q("full_pp_rd", 1'b0);

        // New overflow and ovf_clr in the same cycle: set wins.
        for (int i = 0; i < 4; i++) push(0, 8'(8'hC0 + i));
        uart_update[0] = 1'b1;
        uart_data[7:0] = 8'hC4;
        ovf_clr[0] = 1'b1;
        tick();
        uart_update = '0;
        ovf_clr = '0;
        check("ovf_set_wins", 32'(overflow), 32'b01);
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr = '0;
        check("ovf_clr2", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) read_byte("ovf_c_rd", 8'(8'hC0 + i), 1'b0);

        // Arbitration from a fresh reset: ch0={01,02}, ch1={81}.
        do_reset();
        uart_update = 2'b11;
        uart_data   = {8'h81, 8'h01};
        tick();
        uart_update = '0;
        push(0, 8'h02);
`ifdef UART_INTR_FIFO_RR_EN
        read_byte("arb0", 8'h01, 1'b0);
        read_byte("arb1", 8'h81, 1'b1);
        read_byte("arb2", 8'h02, 1'b0);
`else
        read_byte("arb0", 8'h01, 1'b0);
        read_byte("arb1", 8'h02, 1'b0);
        read_byte("arb2", 8'h81, 1'b1);
`endif
        quiet("arb_quiet", 4);

        // Ack held high for 10 cycles with 3 bytes buffered.
        for (int i = 0; i < 3; i++) begin
            push(1, 8'(8'h31 + i));
            exp_q.push_back(8'(8'h31 + i));
        end
        wait_irr("hold_irr");
        irr_trace = '0;
        pops = 0;
        ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            irr_trace[i] = irr;
            if (irr === 1'b1) begin
                pops++;
                if (exp_q.size() > 0) check("hold_data", 32'(r_data), 32'(exp_q.pop_front()));
                else check("hold_extra", 32'(r_data), 32'hFFFF_FFFF);
            end
            tick();
        end
        ack = 1'b0;
        check("hold_trace", 32'(irr_trace), 32'b00_0100_1001);
        check("hold_pops", 32'(pops), 32'd3);
        exp_q.delete();
        quiet("hold_quiet", 4);

        // Reset mid-handshake discards buffered and presented bytes.
        push(0, 8'h55);
        push(0, 8'h66);
        wait_irr("rstmid_irr");
        reset = 1'b1;
        #1;
        check("rstmid_irr0", 32'(irr), 32'd0);
        check("rstmid_data0", 32'(r_data), 32'd0);
        check("rstmid_chan0", 32'(r_chan), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        quiet("rstmid_quiet", 6);
        push(0, 8'h77);
        read_byte("rstmid_new", 8'h77, 1'b0);
        quiet("rstmid_end", 4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
